output_window_stats: RTL

Downstream statistics stage for the 16-bit filter output of `FPGA_Top_Level`. It consumes one signed sample per enabled clock and accumulates non-overlapping windows of `WINDOW_LEN` samples. For each window it produces the sum, minimum and maximum through a valid/ready output register. Accumulation of the next window continues while a result waits, and a sticky overrun flag records any window dropped because the consumer stalled.

---
 rtl/output_window_stats.sv | 126 ++++++++++++
 1 files changed

// File: rtl/output_window_stats.sv
// Windowed sum/min/max of a signed 16-bit sample stream.
// Ports: clk, reset (sync, active-high), clk_enable + data_in in,
//   out_ready in; out_valid, win_sum, win_min, win_max, overrun out.
module output_window_stats #(
  parameter int WINDOW_LEN = 16,
  parameter int LOG2_WIN   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  input  logic [15:0]           data_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [16+LOG2_WIN-1:0] win_sum,
  output logic [15:0]           win_min,
  output logic [15:0]           win_max,
  output logic                  overrun
);

  localparam int SW = 16 + LOG2_WIN;
  localparam logic [LOG2_WIN-1:0] CNT_LAST =
    LOG2_WIN'(WINDOW_LEN - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state;
  state_t state_nx;

  logic [LOG2_WIN-1:0]  cnt;
  logic signed [SW-1:0] acc_sum;
  logic signed [15:0]   acc_min;
  logic signed [15:0]   acc_max;

  logic signed [15:0]   sample;
  logic signed [SW-1:0] sample_x;
  logic signed [SW-1:0] sum_nx;
  logic signed [15:0]   min_nx;
  logic signed [15:0]   max_nx;

  logic first;
  logic done;
  logic load;
  logic ovr_set;

  assign sample   = data_in;
  assign sample_x = {{LOG2_WIN{data_in[15]}}, data_in};
  assign first    = (cnt == '0);
  assign done     = clk_enable && (cnt == CNT_LAST);

  // Accumulator values including the current sample; these are
  // what a completing window hands to the output register.
  always_comb begin
    sum_nx = acc_sum + sample_x;
    min_nx = acc_min;
    max_nx = acc_max;
    if (first) begin
      sum_nx = sample_x;
      min_nx = sample;
      max_nx = sample;
    end else begin
      if (sample < acc_min) min_nx = sample;
      if (sample > acc_max) max_nx = sample;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      acc_sum <= '0;
      acc_min <= '0;
      acc_max <= '0;
    end else if (clk_enable) begin
      cnt     <= done ? '0 : cnt + 1'b1;
      acc_sum <= sum_nx;
      acc_min <= min_nx;
      acc_max <= max_nx;
    end
  end

  // A completion while FULL is only accepted if the old result
  // leaves in the same cycle; otherwise the new window is lost.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    ovr_set  = 1'b0;
    unique case (state)
      EMPTY: begin
        if (done) begin
          load     = 1'b1;
          state_nx = FULL;
        end
      end
      FULL: begin
        if (done && out_ready) begin
          load = 1'b1;
        end else if (done) begin
          ovr_set = 1'b1;
        end else if (out_ready) begin
          state_nx = EMPTY;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      win_sum <= '0;
      win_min <= '0;
      win_max <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        win_sum <= sum_nx;
        win_min <= min_nx;
        win_max <= max_nx;
      end
      if (ovr_set) overrun <= 1'b1;
    end
  end

  assign out_valid = (state == FULL);

endmodule
